dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the pipelined RV32 core. It sits on the MEM-stage side of the load/store path and accepts one load or store request at a time through a valid/ready handshake. It models a configurable number of wait states, performs byte, halfword or word accesses with RV32 load extension, and returns a one-cycle response pulse. It also drives a stall signal that the hazard logic uses to freeze the pipeline while an access is outstanding.

---
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, LATENCY wait states,
// RV32 byte/half/word lanes with load extension, one-cycle response pulse and pipeline stall.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_stall
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        we_reg, unsigned_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [1:0]  size_reg;
  logic        err_reg, load_ok_reg;
  logic        accept, commit, wr_en;

  logic        a_we, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;
  logic [AW-1:0] a_idx;
  logic [3:0]  lane_en;
  logic [31:0] lane_wdata, rd_word, ext_word;
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      err_reg      <= 1'b0;
      load_ok_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (commit) begin
        err_reg     <= a_err;
        load_ok_reg <= !a_we && !a_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg       <= req_we;
      addr_reg     <= req_addr;
      wdata_reg    <= req_wdata;
      size_reg     <= req_size;
      unsigned_reg <= req_unsigned;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    accept        = 1'b0;
    commit        = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept        = 1'b1;
          wait_cnt_next = 4'(LATENCY);
          if (LATENCY > 0) begin
            state_next = WAIT;
          end else begin
            state_next = RESP;
            commit     = 1'b1;
          end
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt_reg - 4'd1;
        if (wait_cnt_reg == 4'd1) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_stall = (req_valid && state_reg == IDLE) || state_reg == WAIT;

  // With zero latency the commit edge is also the accept edge, so the live request is used.
  assign a_we    = accept ? req_we    : we_reg;
  assign a_addr  = accept ? req_addr  : addr_reg;
  assign a_wdata = accept ? req_wdata : wdata_reg;
  assign a_size  = accept ? req_size  : size_reg;
  assign a_idx   = a_addr[AW+1:2];
  assign wr_en   = commit && !reset && a_we && !a_err;

  always_comb begin
    a_err = 1'b0;
    case (a_size)
      2'b00:   a_err = 1'b0;
      2'b01:   a_err = a_addr[0];
      2'b10:   a_err = |a_addr[1:0];
      default: a_err = 1'b1;
    endcase
    if ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS)) a_err = 1'b1;
  end

  always_comb begin
    lane_en    = 4'b1111;
    lane_wdata = a_wdata;
    case (a_size)
      2'b00: begin
        lane_en    = 4'b0001 << a_addr[1:0];
        lane_wdata = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        lane_en    = a_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{a_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
      if (wr_en && lane_en[gi]) lane_mem[a_idx] <= lane_wdata[gi*8 +: 8];
      if (commit) rd_byte[gi] <= lane_mem[a_idx];
    end
  end

  assign rd_word  = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
  assign sel_byte = rd_word[{addr_reg[1:0], 3'b000} +: 8];
  assign sel_half = rd_word[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    ext_word = rd_word;
    case (size_reg)
      2'b00: ext_word = unsigned_reg ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01: ext_word = unsigned_reg ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: ;
    endcase
  end

  assign resp_rdata = load_ok_reg ? ext_word : 32'd0;
  assign resp_err   = err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: byte-array reference model,
// directed plan cases, reset abort, and a zero-latency instance with a held request.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, resp_valid, resp_err, mem_stall;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_we, z_req_unsigned;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [1:0]  z_req_size;
  logic        z_req_ready, z_resp_valid, z_resp_err, z_mem_stall;
  logic [31:0] z_resp_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mem_model [4*DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_stall(mem_stall)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut_zero (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_size(z_req_size),
    .req_unsigned(z_req_unsigned), .req_ready(z_req_ready), .resp_valid(z_resp_valid),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .mem_stall(z_mem_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: little-endian byte memory, alignment/range/size rules, arithmetic extension.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              output logic [31:0] rdata, output logic err);
    int nbytes;
    longint val;
    nbytes = 0;
    err    = 1'b0;
    rdata  = 32'd0;
    case (size)
      2'd0: nbytes = 1;
      2'd1: nbytes = 2;
      2'd2: nbytes = 4;
      default: err = 1'b1;
    endcase
    if (!err && (addr % nbytes) != 0) err = 1'b1;
    if ((addr >> 2) >= DEPTH) err = 1'b1;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nbytes; k++) mem_model[int'(addr) + k] = 8'(wdata >> (8 * k));
      end else begin
        val = 0;
        for (int k = 0; k < nbytes; k++) val += longint'(mem_model[int'(addr) + k]) << (8 * k);
        if (!uns && nbytes < 4 && val >= (64'd1 << (8 * nbytes - 1))) val -= (64'd1 << (8 * nbytes));
        rdata = val[31:0];
      end
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns, output logic [31:0] got);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int stall_cnt, resp_cyc;
    model_access(we, addr, wdata, size, uns, exp_rdata, exp_err);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    stall_cnt = 0; resp_cyc = -1; got = 32'hxxxxxxxx;
    for (int c = 0; c < 20 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 0) chk("ready_at_accept", 32'(req_ready), 32'd1);
      if (mem_stall) stall_cnt++;
      if (resp_valid) begin
        resp_cyc = c;
        got = resp_rdata;
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_rdata", resp_rdata, exp_rdata);
      end
      @(posedge clk); #1;
      if (c == 0) begin
        req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_we = 1'($urandom);
      end
    end
    req_valid = 1'b0;
    chk("resp_latency", 32'(resp_cyc), 32'(LAT + 1));
    chk("stall_cycles", 32'(stall_cnt), 32'(LAT + 1));
    $display("xact we=%0b addr=%08h size=%0d uns=%0b rdata=%08h err=%0b", we, addr, size, uns, got, exp_err);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    for (int i = 0; i < 4 * DEPTH; i++) mem_model[i] = 8'd0;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'd0; req_unsigned = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
    z_req_size = 2'd0; z_req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    xact(1'b1, 32'h40, 32'hDEADBEEF, 2'd2, 1'b0, got);
    xact(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, got);  chk("plan_lw", got, 32'hDEADBEEF);
    xact(1'b0, 32'h43, 32'h0, 2'd0, 1'b0, got);  chk("plan_lb", got, 32'hFFFFFFDE);
    xact(1'b0, 32'h43, 32'h0, 2'd0, 1'b1, got);  chk("plan_lbu", got, 32'h000000DE);
    xact(1'b0, 32'h40, 32'h0, 2'd1, 1'b0, got);  chk("plan_lh", got, 32'hFFFFBEEF);
    xact(1'b1, 32'h41, 32'h12, 2'd0, 1'b0, got);
    xact(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, got);  chk("plan_sb_lw", got, 32'hDEAD12EF);
    xact(1'b0, 32'h42, 32'h0, 2'd2, 1'b0, got);
    xact(1'b1, 32'h41, 32'hFFFF, 2'd1, 1'b0, got);
    xact(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, got);  chk("plan_err_nowrite", got, 32'hDEAD12EF);
    xact(1'b0, 32'(4 * DEPTH), 32'h0, 2'd2, 1'b0, got);
    xact(1'b0, 32'h40, 32'h0, 2'd3, 1'b0, got);

    // Reset during the second WAIT cycle aborts a store.
    xact(1'b1, 32'h80, 32'h12345678, 2'd2, 1'b0, got);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h55;
    req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_accepted", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wait2_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    xact(1'b0, 32'h80, 32'h0, 2'd2, 1'b0, got);  chk("abort_nocommit", got, 32'h12345678);

    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      xact(1'($urandom), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), got);
    end

    // Zero latency: request held continuously, stores then loads of the same word.
    for (int c = 0; c < 12; c++) begin
      z_req_valid = 1'b1;
      z_req_we    = (c < 4);
      z_req_addr  = 32'h4;
      z_req_wdata = 32'hA5A50001;
      z_req_size  = 2'd2;
      @(negedge clk);
      chk("lat0_resp_valid", 32'(z_resp_valid), 32'(c % 2));
      chk("lat0_ready", 32'(z_req_ready), 32'((c + 1) % 2));
      if (z_resp_valid) begin
        chk("lat0_rdata", z_resp_rdata, (c >= 5) ? 32'hA5A50001 : 32'd0);
        chk("lat0_err", 32'(z_resp_err), 32'd0);
      end
      $display("lat0 cycle %0d we=%0b resp_valid=%0b rdata=%08h", c, z_req_we, z_resp_valid, z_resp_rdata);
      @(posedge clk); #1;
    end
    z_req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
